// File: rtl/transform_arbiter.sv
// Round-robin arbiter that shares one transform controller among four requesters.
// Optional BUSY watchdog with core_abort is enabled by defining ARB_TIMEOUT_EN.
module transform_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clock,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [1:0] t_sel0,
  input  logic [1:0] t_sel1,
  input  logic [1:0] t_sel2,
  input  logic [1:0] t_sel3,
  input  logic       core_done,
  output logic [3:0] gnt,
  output logic [3:0] done,
  output logic [3:0] err,
  output logic       core_strt,
  output logic [1:0] core_tsel,
  output logic       core_abort,
  output logic       busy
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit the 8-bit counter (1..255)");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    BUSY    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] tsel_q, tsel_d;
  logic [1:0] last_q, last_d;
  logic       done_q, done_d;
  logic       abort_q, abort_d;

  logic       pick_vld;
  logic [1:0] pick_idx;
  logic [1:0] pick_tsel;
  logic [1:0] cand;
  logic [3:0] idx_oh;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
`endif

  // Scan from lowest to highest priority so the nearest requester after last wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = 2'd0;
    cand     = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      cand = last_q + 2'(i + 1);
      if (req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    pick_tsel = t_sel0;
    unique case (pick_idx)
      2'd0: pick_tsel = t_sel0;
      2'd1: pick_tsel = t_sel1;
      2'd2: pick_tsel = t_sel2;
      2'd3: pick_tsel = t_sel3;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tsel_d  = tsel_q;
    last_d  = last_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          idx_d   = pick_idx;
          tsel_d  = pick_tsel;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = (tsel_q == 2'b00) ? RELEASE : BUSY;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = 8'd0;
`endif
      end
      BUSY: begin
        if (core_done) begin
          done_d  = 1'b1;
          state_d = RELEASE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          abort_d = 1'b1;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      RELEASE: begin
        last_d  = idx_q;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      tsel_q  <= 2'b00;
      last_q  <= 2'd3;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tsel_q  <= tsel_d;
      last_q  <= last_d;
      done_q  <= done_d;
      abort_q <= abort_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign idx_oh    = 4'b0001 << idx_q;
  assign busy      = (state_q != IDLE);
  assign gnt       = (state_q == ISSUE || state_q == BUSY) ? idx_oh : 4'b0;
  assign core_strt = (state_q == ISSUE) && (tsel_q != 2'b00);
  assign core_tsel = busy ? tsel_q : 2'b00;
  assign done      = done_q ? idx_oh : 4'b0;
  assign err       = (((state_q == ISSUE) && (tsel_q == 2'b00)) || abort_q)
                     ? idx_oh : 4'b0;
`ifdef ARB_TIMEOUT_EN
  assign core_abort = abort_q;
`else
  assign core_abort = 1'b0;
`endif

endmodule
